// File: rtl/serial_sum_collector_if.sv
// Bit-stream input and word valid/ready output bundle for serial_sum_collector.
// The slave modport is the collector side; the master modport is the adder/consumer side.
interface serial_sum_collector_if #(
  parameter int WIDTH = 8
);
  logic             bit_valid;
  logic             frame_start;
  logic             S;
  logic             Cout;
  logic [WIDTH-1:0] word_data;
  logic             word_carry;
  logic             word_valid;
  logic             word_ready;
  logic             overrun;
  logic             clr_overrun;

  modport slave (
    input  bit_valid, frame_start, S, Cout, word_ready, clr_overrun,
    output word_data, word_carry, word_valid, overrun
  );

  modport master (
    output bit_valid, frame_start, S, Cout, word_ready, clr_overrun,
    input  word_data, word_carry, word_valid, overrun
  );
endinterface

// File: rtl/serial_sum_collector.sv
// Assembles LSB-first serial sum bits into WIDTH-bit words with the final carry,
// and holds each word in a valid/ready output register with a sticky overrun flag.
module serial_sum_collector #(
  parameter int WIDTH = 8
) (
  input logic                  CLK,
  input logic                  RST,
  serial_sum_collector_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] word_data_r;
  logic             word_carry_r;
  logic             word_valid_r;
  logic             overrun_r;

  logic [WIDTH-1:0] asm_s;
  logic             complete_s;

  // Current shift contents with this cycle's bit merged in, and word-complete detect.
  always_comb begin
    asm_s        = shift_r;
    asm_s[cnt_r] = bus.S;
    complete_s   = (state_r == COLLECT) && bus.bit_valid && !bus.frame_start && (cnt_r == LAST);
  end

  // Bit collection FSM: frame_start always restarts a word, dropping any partial one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.bit_valid && bus.frame_start) begin
            shift_r <= {{(WIDTH-1){1'b0}}, bus.S};
            cnt_r   <= CNT_W'(1);
            state_r <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.bit_valid) begin
            if (bus.frame_start) begin
              shift_r <= {{(WIDTH-1){1'b0}}, bus.S};
              cnt_r   <= CNT_W'(1);
            end else if (cnt_r == LAST) begin
              shift_r <= asm_s;
              cnt_r   <= '0;
              state_r <= IDLE;
            end else begin
              shift_r <= asm_s;
              cnt_r   <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Output register: a completed word refills it only if empty or draining this edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_data_r  <= '0;
      word_carry_r <= 1'b0;
      word_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (complete_s && (!word_valid_r || bus.word_ready)) begin
        word_data_r  <= asm_s;
        word_carry_r <= bus.Cout;
        word_valid_r <= 1'b1;
      end else if (word_valid_r && bus.word_ready) begin
        word_valid_r <= 1'b0;
      end

      if (complete_s && word_valid_r && !bus.word_ready) begin
        overrun_r <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign bus.word_data  = word_data_r;
  assign bus.word_carry = word_carry_r;
  assign bus.word_valid = word_valid_r;
  assign bus.overrun    = overrun_r;
endmodule
